// File: rtl/gpio_regs_pkg.sv
// gpio_regs_pkg
// Shared definitions for the GPIO register bank:
//   - byte base addresses of every register kind (word i of a kind sits at
//     base + 4*i), plus the single IRQ control address
//   - reg_kind_e, the register kind produced by the word decoder
//   - page_of(), the 256-byte page number of a base address (the decoder
//     matches on page, then uses the low address bits as the word index)
package gpio_regs_pkg;

  localparam logic [15:0] DATA_BASE    = 16'h1000;
  localparam logic [15:0] DDR_BASE     = 16'h1100;
  localparam logic [15:0] OD_BASE      = 16'h1300;
  localparam logic [15:0] SET_BASE     = 16'h1400;
  localparam logic [15:0] CLR_BASE     = 16'h1500;
  localparam logic [15:0] RISE_EN_BASE = 16'h1600;
  localparam logic [15:0] FALL_EN_BASE = 16'h1700;
  localparam logic [15:0] EDGE_ST_BASE = 16'h1800;
  localparam logic [15:0] IRQ_CTL_ADDR = 16'h1900;

  typedef enum logic [3:0] {
    KIND_NONE,
    KIND_DATA,
    KIND_DDR,
    KIND_OD,
    KIND_SET,
    KIND_CLR,
    KIND_RISE_EN,
    KIND_FALL_EN,
    KIND_EDGE_ST,
    KIND_IRQ
  } reg_kind_e;

  function automatic logic [7:0] page_of(input logic [15:0] base);
    return base[15:8];
  endfunction

endpackage

// File: rtl/gpio_in_sync_edge.sv
// gpio_in_sync_edge
// Two-flop synchroniser for asynchronous pin inputs, followed by a delay
// flop used for edge detection.
// Ports:
//   clk_i       clock
//   rst_i       asynchronous active-high reset (all flops to 0)
//   din_i       raw pin levels, asynchronous to clk_i
//   rise_en_i   per-pin rising-edge enable
//   fall_en_i   per-pin falling-edge enable
//   in_s_o      synchronised pin levels
//   rise_o      enabled rising edge seen this cycle (in_s & ~in_d)
//   fall_o      enabled falling edge seen this cycle (~in_s & in_d)
module gpio_in_sync_edge #(
  parameter int Width = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [Width-1:0] din_i,
  input  logic [Width-1:0] rise_en_i,
  input  logic [Width-1:0] fall_en_i,
  output logic [Width-1:0] in_s_o,
  output logic [Width-1:0] rise_o,
  output logic [Width-1:0] fall_o
);

  logic [Width-1:0] sync1_q;
  logic [Width-1:0] sync2_q;
  logic [Width-1:0] dly_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
      dly_q   <= '0;
    end else begin
      sync1_q <= din_i;
      sync2_q <= sync1_q;
      dly_q   <= sync2_q;
    end
  end

  assign in_s_o = sync2_q;
  assign rise_o = sync2_q & ~dly_q & rise_en_i;
  assign fall_o = ~sync2_q & dly_q & fall_en_i;

endmodule

// File: rtl/gpio_bank_regs.sv
// gpio_bank_regs
// GPIO register bank: per-pin data, direction and open-drain registers,
// atomic set/clear, synchronised inputs, sticky W1C edge status and a
// registered level interrupt. All state is clocked on reg_clk.
// Ports:
//   reg_clk          register clock
//   reset_in         asynchronous active-high reset
//   chip_sel         qualifies read_reg / write_reg
//   write_reg        one-cycle write strobe
//   read_reg         one-cycle read strobe
//   busaddress       word address (byte address bits [AddrWidth-1:2])
//   busdata_in       write data
//   busdata_fromhm2  read data returned for unmapped addresses
//   gpio_in          raw pin levels (asynchronous)
//   gpio_out         pin drive value
//   gpio_oe          pin output enable
//   busdata_to_cpu   registered read data, held until the next read
//   irq              level interrupt
module gpio_bank_regs
  import gpio_regs_pkg::*;
#(
  parameter int AddrWidth    = 16,
  parameter int BusWidth     = 32,
  parameter int IoRegWidth   = 24,
  parameter int NumIOAddrReg = 6,
  localparam int NumPins     = IoRegWidth * NumIOAddrReg
) (
  input  logic                 reg_clk,
  input  logic                 reset_in,
  input  logic                 chip_sel,
  input  logic                 write_reg,
  input  logic                 read_reg,
  input  logic [AddrWidth-1:2] busaddress,
  input  logic [BusWidth-1:0]  busdata_in,
  input  logic [BusWidth-1:0]  busdata_fromhm2,
  input  logic [NumPins-1:0]   gpio_in,
  output logic [NumPins-1:0]   gpio_out,
  output logic [NumPins-1:0]   gpio_oe,
  output logic [BusWidth-1:0]  busdata_to_cpu,
  output logic                 irq
);

  // ---------------------------------------------------------------------
  // Word decoder: a 256-byte page selects the kind, byte address bits
  // [7:2] select the word (so up to 64 words per kind).
  // ---------------------------------------------------------------------
  logic [AddrWidth-9:0]  page;
  logic [5:0]            word;
  reg_kind_e             kind;
  logic                  wr_en;
  logic                  rd_en;
  logic [IoRegWidth-1:0] wdata;

  assign page  = busaddress[AddrWidth-1:8];
  assign word  = busaddress[7:2];
  assign wr_en = chip_sel & write_reg;
  assign rd_en = chip_sel & read_reg;
  assign wdata = busdata_in[IoRegWidth-1:0];

  function automatic logic page_is(input logic [AddrWidth-9:0] pg,
                                   input logic [15:0] base);
    return pg == (AddrWidth-8)'(page_of(base));
  endfunction

  always_comb begin
    kind = KIND_NONE;
    if (int'(word) < NumIOAddrReg) begin
      if      (page_is(page, DATA_BASE))    kind = KIND_DATA;
      else if (page_is(page, DDR_BASE))     kind = KIND_DDR;
      else if (page_is(page, OD_BASE))      kind = KIND_OD;
      else if (page_is(page, SET_BASE))     kind = KIND_SET;
      else if (page_is(page, CLR_BASE))     kind = KIND_CLR;
      else if (page_is(page, RISE_EN_BASE)) kind = KIND_RISE_EN;
      else if (page_is(page, FALL_EN_BASE)) kind = KIND_FALL_EN;
      else if (page_is(page, EDGE_ST_BASE)) kind = KIND_EDGE_ST;
    end
    if (page_is(page, IRQ_CTL_ADDR) && word == 6'd0) kind = KIND_IRQ;
  end

  // ---------------------------------------------------------------------
  // Input synchroniser and edge detect across all pins
  // ---------------------------------------------------------------------
  logic [NumPins-1:0] in_s;
  logic [NumPins-1:0] rise;
  logic [NumPins-1:0] fall;
  logic [NumPins-1:0] rise_en_flat;
  logic [NumPins-1:0] fall_en_flat;
  logic [NumPins-1:0] edge_flat;

  gpio_in_sync_edge #(
    .Width(NumPins)
  ) u_sync (
    .clk_i    (reg_clk),
    .rst_i    (reset_in),
    .din_i    (gpio_in),
    .rise_en_i(rise_en_flat),
    .fall_en_i(fall_en_flat),
    .in_s_o   (in_s),
    .rise_o   (rise),
    .fall_o   (fall)
  );

  // ---------------------------------------------------------------------
  // Per-word register slices
  // ---------------------------------------------------------------------
  logic [IoRegWidth-1:0] in_word      [NumIOAddrReg];
  logic [IoRegWidth-1:0] ddr_word     [NumIOAddrReg];
  logic [IoRegWidth-1:0] od_word      [NumIOAddrReg];
  logic [IoRegWidth-1:0] rise_en_word [NumIOAddrReg];
  logic [IoRegWidth-1:0] fall_en_word [NumIOAddrReg];
  logic [IoRegWidth-1:0] edge_word    [NumIOAddrReg];

  for (genvar gi = 0; gi < NumIOAddrReg; gi++) begin : g_word
    localparam int Lo = gi * IoRegWidth;

    logic                  hit;
    logic [IoRegWidth-1:0] io_q, io_d;
    logic [IoRegWidth-1:0] ddr_q, ddr_d;
    logic [IoRegWidth-1:0] od_q, od_d;
    logic [IoRegWidth-1:0] rise_en_q, rise_en_d;
    logic [IoRegWidth-1:0] fall_en_q, fall_en_d;
    logic [IoRegWidth-1:0] edge_q, edge_d;
    logic [IoRegWidth-1:0] w1c;

    assign hit = wr_en && (word == 6'(gi));

    always_comb begin
      io_d      = io_q;
      ddr_d     = ddr_q;
      od_d      = od_q;
      rise_en_d = rise_en_q;
      fall_en_d = fall_en_q;
      w1c       = '0;
      if (hit) begin
        case (kind)
          KIND_DATA:    io_d      = wdata;
          KIND_SET:     io_d      = io_q | wdata;
          KIND_CLR:     io_d      = io_q & ~wdata;
          KIND_DDR:     ddr_d     = wdata;
          KIND_OD:      od_d      = wdata;
          KIND_RISE_EN: rise_en_d = wdata;
          KIND_FALL_EN: fall_en_d = wdata;
          KIND_EDGE_ST: w1c       = wdata;
          default: ;
        endcase
      end
      // Clear first, then OR in new edges: a fresh edge survives a
      // same-cycle write-1-to-clear.
      edge_d = (edge_q & ~w1c) | rise[Lo +: IoRegWidth] | fall[Lo +: IoRegWidth];
    end

    always_ff @(posedge reg_clk or posedge reset_in) begin
      if (reset_in) begin
        io_q      <= '0;
        ddr_q     <= '0;
        od_q      <= '0;
        rise_en_q <= '0;
        fall_en_q <= '0;
        edge_q    <= '0;
      end else begin
        io_q      <= io_d;
        ddr_q     <= ddr_d;
        od_q      <= od_d;
        rise_en_q <= rise_en_d;
        fall_en_q <= fall_en_d;
        edge_q    <= edge_d;
      end
    end

    // Open-drain pins only ever pull low: drive enabled when io is 0.
    assign gpio_out[Lo +: IoRegWidth] = io_q & ~od_q;
    assign gpio_oe[Lo +: IoRegWidth]  = (od_q & ~io_q) | (~od_q & ddr_q);

    assign rise_en_flat[Lo +: IoRegWidth] = rise_en_q;
    assign fall_en_flat[Lo +: IoRegWidth] = fall_en_q;
    assign edge_flat[Lo +: IoRegWidth]    = edge_q;

    assign in_word[gi]      = in_s[Lo +: IoRegWidth];
    assign ddr_word[gi]     = ddr_q;
    assign od_word[gi]      = od_q;
    assign rise_en_word[gi] = rise_en_q;
    assign fall_en_word[gi] = fall_en_q;
    assign edge_word[gi]    = edge_q;
  end

  if (BusWidth > IoRegWidth) begin : g_upper
    logic unused_upper;
    assign unused_upper = ^busdata_in[BusWidth-1:IoRegWidth];
  end

  // ---------------------------------------------------------------------
  // IRQ control, interrupt and read mux
  // ---------------------------------------------------------------------
  logic                  irq_en_q, irq_en_d;
  logic                  irq_q, irq_d;
  logic [BusWidth-1:0]   busdata_q, busdata_d;
  logic [IoRegWidth-1:0] rd_field;

  always_comb begin
    irq_en_d = irq_en_q;
    if (wr_en && kind == KIND_IRQ) irq_en_d = busdata_in[0];
    irq_d = irq_en_q & (|edge_flat);
  end

  always_comb begin
    rd_field = '0;
    for (int w = 0; w < NumIOAddrReg; w++) begin
      if (int'(word) == w) begin
        case (kind)
          KIND_DATA:    rd_field = in_word[w];
          KIND_DDR:     rd_field = ddr_word[w];
          KIND_OD:      rd_field = od_word[w];
          KIND_RISE_EN: rd_field = rise_en_word[w];
          KIND_FALL_EN: rd_field = fall_en_word[w];
          KIND_EDGE_ST: rd_field = edge_word[w];
          default: ;
        endcase
      end
    end
    busdata_d = busdata_q;
    if (rd_en) begin
      case (kind)
        KIND_NONE: busdata_d = busdata_fromhm2;
        KIND_IRQ:  busdata_d = BusWidth'(irq_en_q);
        default:   busdata_d = BusWidth'(rd_field);
      endcase
    end
  end

  always_ff @(posedge reg_clk or posedge reset_in) begin
    if (reset_in) begin
      irq_en_q  <= 1'b0;
      irq_q     <= 1'b0;
      busdata_q <= '0;
    end else begin
      irq_en_q  <= irq_en_d;
      irq_q     <= irq_d;
      busdata_q <= busdata_d;
    end
  end

  assign busdata_to_cpu = busdata_q;
  assign irq            = irq_q;

endmodule

// File: tb/tb_gpio_bank_regs.sv
module tb_gpio_bank_regs;
  localparam int AW = 16;
  localparam int BW = 32;
  localparam int IW = 24;
  localparam int NW = 6;
  localparam int NP = IW * NW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cs = 1'b0, wr = 1'b0, rd = 1'b0;
  logic [AW-1:2] addr = '0;
  logic [BW-1:0] wdata = '0, hm2 = '0;
  logic [NP-1:0] gin = '0;
  logic [NP-1:0] gout, goe;
  logic [BW-1:0] bdata;
  logic          irq;

  always #5 clk = ~clk;

  gpio_bank_regs dut (
    .reg_clk        (clk),
    .reset_in       (rst),
    .chip_sel       (cs),
    .write_reg      (wr),
    .read_reg       (rd),
    .busaddress     (addr),
    .busdata_in     (wdata),
    .busdata_fromhm2(hm2),
    .gpio_in        (gin),
    .gpio_out       (gout),
    .gpio_oe        (goe),
    .busdata_to_cpu (bdata),
    .irq            (irq)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [NP-1:0] got, input logic [NP-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [IW-1:0] m_io[NW], m_ddr[NW], m_od[NW], m_re[NW], m_fe[NW], m_st[NW];
  logic          m_en, m_irq;
  logic [BW-1:0] m_bus;
  logic [NP-1:0] h0, h1, h2;   // gpio_in as sampled at the last three edges

  // kinds: 0 DATA 1 DDR 2 OD 3 SET 4 CLR 5 RISE 6 FALL 7 EDGE 8 IRQ, -1 none
  function automatic int base_of(input int j);
    case (j)
      0: return 'h1000;  1: return 'h1100;  2: return 'h1300;  3: return 'h1400;
      4: return 'h1500;  5: return 'h1600;  6: return 'h1700;  default: return 'h1800;
    endcase
  endfunction

  task automatic decode(input int a, output int k, output int idx);
    k = -1; idx = 0;
    for (int j = 0; j < 8; j++)
      if (a >= base_of(j) && a < base_of(j) + 4 * NW) begin k = j; idx = (a - base_of(j)) / 4; end
    if (a == 'h1900) k = 8;
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      for (int w = 0; w < NW; w++) begin
        m_io[w] = 0; m_ddr[w] = 0; m_od[w] = 0; m_re[w] = 0; m_fe[w] = 0; m_st[w] = 0;
      end
      m_en = 0; m_irq = 0; m_bus = 0; h0 = 0; h1 = 0; h2 = 0;
    end else begin
      int a, k, idx;
      logic [NP-1:0] re_f, fe_f, rise_v, fall_v;
      logic [IW-1:0] w1c[NW];
      logic [IW-1:0] d;
      logic any_st;
      any_st = 0;
      for (int w = 0; w < NW; w++) begin
        re_f[w*IW +: IW] = m_re[w];
        fe_f[w*IW +: IW] = m_fe[w];
        w1c[w] = 0;
        if (m_st[w] != 0) any_st = 1;
      end
      rise_v = h1 & ~h2 & re_f;
      fall_v = ~h1 & h2 & fe_f;
      a = int'({addr, 2'b00});
      decode(a, k, idx);
      d = wdata[IW-1:0];
      if (cs && rd) begin
        case (k)
          -1: m_bus = hm2;
          0: m_bus = BW'(h1[idx*IW +: IW]);
          1: m_bus = BW'(m_ddr[idx]);
          2: m_bus = BW'(m_od[idx]);
          5: m_bus = BW'(m_re[idx]);
          6: m_bus = BW'(m_fe[idx]);
          7: m_bus = BW'(m_st[idx]);
          8: m_bus = BW'(m_en);
          default: m_bus = 0;
        endcase
      end
      if (cs && wr) begin
        case (k)
          0: m_io[idx] = d;
          1: m_ddr[idx] = d;
          2: m_od[idx] = d;
          3: m_io[idx] = m_io[idx] | d;
          4: m_io[idx] = m_io[idx] & ~d;
          5: m_re[idx] = d;
          6: m_fe[idx] = d;
          7: w1c[idx] = d;
          8: m_en = wdata[0];
          default: ;
        endcase
      end
      for (int w = 0; w < NW; w++)
        m_st[w] = (m_st[w] & ~w1c[w]) | rise_v[w*IW +: IW] | fall_v[w*IW +: IW];
      m_irq = (k == 8 && cs && wr) ? m_irq : m_irq;
      m_irq = any_st & m_en_prev(m_en, k, cs, wr);
      h2 = h1; h1 = h0; h0 = gin;
    end
  end

  // enable as it was before this edge's write
  logic m_en_old = 1'b0;
  function automatic logic m_en_prev(input logic en_now, input int k, input logic c, input logic w);
    return (k == 8 && c && w) ? m_en_old : en_now;
  endfunction
  initial forever begin
    @(negedge clk);
    m_en_old = m_en;
  end

  // ---------------- continuous compare ----------------
  initial forever begin
    logic [NP-1:0] e_out, e_oe;
    @(negedge clk);
    for (int w = 0; w < NW; w++) begin
      e_out[w*IW +: IW] = m_io[w] & ~m_od[w];
      e_oe[w*IW +: IW]  = (m_od[w] & ~m_io[w]) | (~m_od[w] & m_ddr[w]);
    end
    chk("cyc_gpio_out", gout, e_out);
    chk("cyc_gpio_oe", goe, e_oe);
    chk("cyc_irq", NP'(irq), NP'(m_irq));
    chk("cyc_bus", NP'(bdata), NP'(m_bus));
  end

  // ---------------- stimulus ----------------
  task automatic bus(input logic c, input logic w, input logic r, input int a, input logic [BW-1:0] d);
    cs = c; wr = w; rd = r; addr = (AW-2)'(a >> 2); wdata = d;
    @(posedge clk); #1;
    cs = 0; wr = 0; rd = 0;
  endtask

  task automatic wr_reg(input int a, input logic [BW-1:0] d);
    bus(1, 1, 0, a, d);
  endtask

  task automatic rd_chk(input string name, input int a, input logic [BW-1:0] exp);
    bus(1, 0, 1, a, 0);
    chk(name, NP'(bdata), NP'(exp));
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    hm2 = 32'hCAFE0001;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    chk("rst_oe", goe, 0);
    chk("rst_out", gout, 0);
    chk("rst_irq", NP'(irq), 0);
    chk("rst_bus", NP'(bdata), 0);
    rd_chk("ddr0_rst", 'h1100, 0);
    rd_chk("edge0_rst", 'h1800, 0);

    // atomic set / clear
    wr_reg('h1100, 'hFFFFFF);
    wr_reg('h1000, 'h00F0F0);
    wr_reg('h1400, 'h000F00);
    wr_reg('h1500, 'h0000F0);
    chk("atomic_out", NP'(gout[23:0]), 'h00FF00);
    chk("atomic_oe", NP'(goe[23:0]), 'hFFFFFF);
    rd_chk("set0_rd", 'h1400, 0);
    rd_chk("clr0_rd", 'h1500, 0);

    // open drain
    wr_reg('h1304, 'h1);
    wr_reg('h1104, 'h0);
    wr_reg('h1004, 'h0);
    chk("od_oe_low", NP'(goe[24]), 1);
    chk("od_out_low", NP'(gout[24]), 0);
    wr_reg('h1004, 'h1);
    chk("od_oe_high", NP'(goe[24]), 0);
    chk("od_out_high", NP'(gout[24]), 0);

    // chip_sel gating and upper-bit truncation
    bus(0, 1, 0, 'h110C, 'hABCDEF);
    rd_chk("cs_gate", 'h110C, 0);
    wr_reg('h1604, 'hFF123456);
    rd_chk("upper_ign", 'h1604, 'h123456);

    // edge capture and interrupt latency
    wr_reg('h1600, 'h1);
    wr_reg('h1900, 'h1);
    gin[0] = 1'b1;
    idle(3);
    chk("irq_e3", NP'(irq), 0);
    idle(1);
    chk("irq_e4", NP'(irq), 1);
    rd_chk("edge0_set", 'h1800, 'h1);
    rd_chk("data0_in", 'h1000, 'h1);
    rd_chk("irqctl_rd", 'h1900, 'h1);
    wr_reg('h1800, 'h1);
    chk("irq_w1c_e1", NP'(irq), 1);
    idle(1);
    chk("irq_w1c_e2", NP'(irq), 0);
    rd_chk("edge0_clr", 'h1800, 0);

    // W1C in the same cycle as a new rising edge
    gin[0] = 1'b0;
    idle(4);
    gin[0] = 1'b1;
    idle(2);
    wr_reg('h1800, 'h1);
    rd_chk("set_wins", 'h1800, 'h1);
    wr_reg('h1800, 'h1);
    idle(2);

    // unmapped reads and writes
    hm2 = 32'hDEADBEEF;
    rd_chk("unmapped", 'h2000, 'hDEADBEEF);
    rd_chk("hole_1200", 'h1200, 'hDEADBEEF);
    rd_chk("past_end", 'h1018, 'hDEADBEEF);
    wr_reg('h1018, 'hFFFFFF);

    // read and write to the same address in one cycle
    wr_reg('h1108, 'h00000F);
    bus(1, 1, 1, 'h1108, 'h123456);
    chk("rw_old", NP'(bdata), 'h0F);
    rd_chk("rw_new", 'h1108, 'h123456);

    // mixed rise/fall enables on word 5
    wr_reg('h1714, 'hFFFFFF);
    wr_reg('h1614, 'h00FF00);
    gin[120 +: 24] = 24'h0000FF; idle(2);
    gin[120 +: 24] = 24'h000000; idle(2);
    gin[120 +: 24] = 24'h00FF00; idle(4);
    rd_chk("edge5_mix", 'h1814, 'h00FFFF);
    rd_chk("data5_in", 'h1014, 'h00FF00);

    // reset in the middle of a pending write
    cs = 1; wr = 1; addr = (AW-2)'('h1110 >> 2); wdata = 'hFFFFFF;
    #2 rst = 1;
    @(posedge clk); #1;
    cs = 0; wr = 0;
    rst = 0;
    chk("rst_mid_oe", goe, 0);
    chk("rst_mid_irq", NP'(irq), 0);
    rd_chk("rst_mid_ddr4", 'h1110, 0);
    rd_chk("rst_mid_ddr0", 'h1100, 0);
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
